// File: rtl/vending_pkg.sv
// ---------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the coffee vending front end:
//   - coin codes driven on the vending FSM's amt bus (code == value)
//   - coffee status code for "cup dispensed"
//   - coin acceptor FSM state type
//   - helper that maps a one-hot sensor edge vector to its coin code
// ---------------------------------------------------------------------------
package vending_pkg;

    localparam logic [4:0] COIN5   = 5'd5;
    localparam logic [4:0] COIN10  = 5'd10;
    localparam logic [4:0] COIN15  = 5'd15;
    localparam logic [4:0] COIN20  = 5'd20;

    localparam logic [1:0] CUP_OUT = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        WAIT_DISP
    } acc_state_t;

    // Only meaningful for a single set bit; anything else maps to 0.
    function automatic logic [4:0] coin_code(input logic [3:0] onehot);
        logic [4:0] code;
        case (onehot)
            4'b0001: code = COIN5;
            4'b0010: code = COIN10;
            4'b0100: code = COIN15;
            4'b1000: code = COIN20;
            default: code = '0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/coin_fifo.sv
// ---------------------------------------------------------------------------
// coin_fifo
// Synchronous show-ahead FIFO holding accepted coin codes.
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset (empties the FIFO)
//   wr_en    in   push wr_data (ignored while full)
//   wr_data  in   coin code to push
//   rd_en    in   pop the head entry (ignored while empty)
//   rd_data  out  head entry, valid whenever empty is low
//   full     out  DEPTH entries held
//   empty    out  no entries held
// DEPTH must be a power of two, 2 or more. A push and a pop in the same cycle
// both take effect and leave the occupancy unchanged.
// ---------------------------------------------------------------------------
module coin_fifo
    import vending_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 5
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/coin_acceptor.sv
// ---------------------------------------------------------------------------
// coin_acceptor
// Front end for the coffee vending FSM. Synchronises and edge-detects the
// one-hot coin sensors, queues accepted coins, and forwards each coin as a
// single-cycle code on amt while keeping a mirror of the vending credit.
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   coin_in      in   raw sensor levels (bit0=5, bit1=10, bit2=15, bit3=20)
//   coffee       in   dispense status; CUP_OUT when a cup has been dispensed
//   amt          out  coin code to the vending FSM, 0 when idle
//   coin_reject  out  one-cycle pulse per returned coin (merged if two coincide)
//   credit       out  mirrored credit, 0..PRICE
//   busy         out  FSM not IDLE, or coins waiting in the queue
//   fault        out  sticky dispense-timeout flag, cleared only by rst
// ---------------------------------------------------------------------------
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PRICE        = 20,
    parameter int unsigned DISP_TIMEOUT = 8
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] coin_in,
    input  logic [1:0] coffee,
    output logic [4:0] amt,
    output logic       coin_reject,
    output logic [4:0] credit,
    output logic       busy,
    output logic       fault
);

    localparam int unsigned TW = $clog2(DISP_TIMEOUT + 1);

    // ---------------- input path ----------------
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] prev;
    logic [3:0] coin_edge;
    logic       multi_edge;
    logic       single_edge;
    logic       in_reject;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= coin_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign coin_edge   = sync2 & ~prev;
    // x & (x-1) is nonzero exactly when more than one bit is set.
    assign multi_edge  = |(coin_edge & (coin_edge - 4'd1));
    assign single_edge = (|coin_edge) && !multi_edge;

    // ---------------- coin queue ----------------
    logic       fifo_full;
    logic       fifo_empty;
    logic [4:0] head;
    logic       pop;

    assign in_reject = multi_edge || (single_edge && fifo_full);

    coin_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (5)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (single_edge),
        .wr_data (coin_code(coin_edge)),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // ---------------- FSM ----------------
    acc_state_t  state;
    logic [TW-1:0] disp_tmr;
    logic [5:0]  sum;
    logic        fits;

    // The head coin is consumed in IDLE whether it is accepted or rejected.
    assign pop  = (state == IDLE) && !fifo_empty;
    assign sum  = {1'b0, credit} + {1'b0, head};
    assign fits = (sum <= 6'(PRICE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            amt         <= '0;
            coin_reject <= 1'b0;
            credit      <= '0;
            fault       <= 1'b0;
            disp_tmr    <= '0;
        end else begin
            amt         <= '0;
            // Input-side and pop-side rejects in the same cycle merge into one pulse.
            coin_reject <= in_reject;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (fits) begin
                            amt    <= head;
                            credit <= sum[4:0];
                            state  <= SEND;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    state <= GAP;
                end
                GAP: begin
                    disp_tmr <= '0;
                    state    <= (credit == 5'(PRICE)) ? WAIT_DISP : IDLE;
                end
                WAIT_DISP: begin
                    if (coffee == CUP_OUT) begin
                        credit <= '0;
                        state  <= IDLE;
                    end else if (disp_tmr == TW'(DISP_TIMEOUT - 1)) begin
                        fault  <= 1'b1;
                        credit <= '0;
                        state  <= IDLE;
                    end else begin
                        disp_tmr <= disp_tmr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE) || !fifo_empty;

endmodule
